route_decision_sequencer: RTL and testbench

Sequences one epsilon-greedy routing decision per request. It scans the Q-table row for the requested destination and tracks the best neighbor value and ID. It then hands that result to the winner-policy unit through a start/done handshake and returns the chosen next hop. It also owns the epsilon register and decays it on a fixed decision interval. It sits between the packet-forwarding front end and the winner-policy / Q-table memory.

---
 rtl/route_decision_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_route_decision_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_decision_sequencer.sv
// Epsilon-greedy next-hop sequencer: scans one Q-table row for the best neighbor and
// hands it to the winner-policy unit. It also owns epsilon and decays it every DECAY_INTERVAL good decisions.
module route_decision_sequencer #(
  parameter int          NBR_W          = 3,
  parameter int          DEST_W         = 7,
  parameter logic [15:0] EPS_INIT       = 16'd1000,
  parameter logic [15:0] EPS_MIN        = 16'd50,
  parameter logic [15:0] EPS_STEP       = 16'd10,
  parameter int          DECAY_INTERVAL = 16,
  parameter int          WP_TIMEOUT     = 64
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DEST_W-1:0]       req_dest,
  input  logic [NBR_W:0]          req_nbr_count,
  output logic                    q_rd_en,
  output logic [DEST_W+NBR_W-1:0] q_addr,
  input  logic [15:0]             q_rdata,
  input  logic [15:0]             nid_rdata,
  output logic                    wp_start,
  output logic [15:0]             wp_bestvalue,
  output logic [15:0]             wp_bestneighborID,
  input  logic                    wp_done,
  input  logic [15:0]             wp_nexthop,
  output logic [15:0]             epsilon,
  output logic                    resp_valid,
  output logic [15:0]             resp_nexthop,
  output logic                    resp_err
);

  localparam int                ADDR_W     = DEST_W + NBR_W;
  localparam int                CNT_W      = $clog2(DECAY_INTERVAL + 1);
  localparam int                TMO_W      = $clog2(WP_TIMEOUT + 1);
  localparam logic [NBR_W:0]    MAX_NBR    = (NBR_W + 1)'(2 ** NBR_W);
  localparam logic [NBR_W:0]    NBR_ONE    = (NBR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  DECAY_LAST = CNT_W'(DECAY_INTERVAL - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(WP_TIMEOUT - 1);
  localparam logic [15:0]       NO_HOP     = 16'hFFFF;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_POLICY, S_RESP} state_e;

  // Saturating decay that never drops below the floor
  function automatic logic [15:0] eps_decay(input logic [15:0] e);
    logic [15:0] dec;
    dec = (e > EPS_STEP) ? (e - EPS_STEP) : 16'd0;
    return (dec > EPS_MIN) ? dec : EPS_MIN;
  endfunction

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               q_rd_en_q, q_rd_en_d;
  logic [ADDR_W-1:0]  q_addr_q, q_addr_d;
  logic [NBR_W:0]     n_q, n_d;
  logic               rd_pend_q, rd_pend_d;
  logic               first_q, first_d;
  logic [15:0]        best_q, best_d;
  logic [15:0]        best_id_q, best_id_d;
  logic               wp_start_q, wp_start_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               resp_valid_q, resp_valid_d;
  logic [15:0]        resp_nexthop_q, resp_nexthop_d;
  logic               resp_err_q, resp_err_d;
  logic [15:0]        eps_q, eps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBR_W:0]     cnt_clamp_s;
  logic [NBR_W:0]     idx_ext_s;
  logic               ok_s;

  assign cnt_clamp_s = (req_nbr_count > MAX_NBR) ? MAX_NBR : req_nbr_count;
  assign idx_ext_s   = {1'b0, q_addr_q[NBR_W-1:0]};

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    q_rd_en_d      = q_rd_en_q;
    q_addr_d       = q_addr_q;
    n_d            = n_q;
    rd_pend_d      = q_rd_en_q;
    first_d        = first_q;
    best_d         = best_q;
    best_id_d      = best_id_q;
    wp_start_d     = wp_start_q;
    tmo_d          = tmo_q;
    resp_valid_d   = 1'b0;
    resp_nexthop_d = resp_nexthop_q;
    resp_err_d     = resp_err_q;
    eps_d          = eps_q;
    cnt_d          = cnt_q;
    ok_s           = 1'b0;

    // Strict compare keeps the lowest index on ties; the first read always wins
    if (rd_pend_q && (first_q || (q_rdata > best_q))) begin
      best_d    = q_rdata;
      best_id_d = nid_rdata;
      first_d   = 1'b0;
    end else begin
      first_d   = first_q;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          n_d         = cnt_clamp_s;
          best_d      = 16'd0;
          best_id_d   = 16'd0;
          first_d     = 1'b1;
          if (cnt_clamp_s == {(NBR_W + 1){1'b0}}) begin
            state_d = S_RESP;
          end else begin
            state_d   = S_SCAN;
            q_rd_en_d = 1'b1;
            q_addr_d  = {req_dest, {NBR_W{1'b0}}};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (idx_ext_s == (n_q - NBR_ONE)) begin
          q_rd_en_d = 1'b0;
          state_d   = S_DRAIN;
        end else begin
          q_addr_d  = q_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        state_d    = S_POLICY;
        wp_start_d = 1'b1;
        tmo_d      = {TMO_W{1'b0}};
      end
      S_POLICY: begin
        if (wp_done) begin
          wp_start_d     = 1'b0;
          state_d        = S_RESP;
          resp_valid_d   = 1'b1;
          resp_nexthop_d = wp_nexthop;
          resp_err_d     = 1'b0;
          ok_s           = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          wp_start_d     = 1'b0;
          state_d        = S_RESP;
          resp_valid_d   = 1'b1;
          resp_nexthop_d = NO_HOP;
          resp_err_d     = 1'b1;
        end else begin
          tmo_d          = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        // Empty-row requests arrive here without a pulse yet and emit it one cycle later
        if (resp_valid_q) begin
          state_d        = S_IDLE;
          req_ready_d    = 1'b1;
        end else begin
          resp_valid_d   = 1'b1;
          resp_nexthop_d = NO_HOP;
          resp_err_d     = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        q_rd_en_d   = 1'b0;
        wp_start_d  = 1'b0;
      end
    endcase

    if (ok_s) begin
      if (cnt_q == DECAY_LAST) begin
        cnt_d = {CNT_W{1'b0}};
        eps_d = eps_decay(eps_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b1;
      q_rd_en_q      <= 1'b0;
      q_addr_q       <= {ADDR_W{1'b0}};
      n_q            <= {(NBR_W + 1){1'b0}};
      rd_pend_q      <= 1'b0;
      first_q        <= 1'b0;
      best_q         <= 16'd0;
      best_id_q      <= 16'd0;
      wp_start_q     <= 1'b0;
      tmo_q          <= {TMO_W{1'b0}};
      resp_valid_q   <= 1'b0;
      resp_nexthop_q <= 16'd0;
      resp_err_q     <= 1'b0;
      eps_q          <= EPS_INIT;
      cnt_q          <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      q_rd_en_q      <= q_rd_en_d;
      q_addr_q       <= q_addr_d;
      n_q            <= n_d;
      rd_pend_q      <= rd_pend_d;
      first_q        <= first_d;
      best_q         <= best_d;
      best_id_q      <= best_id_d;
      wp_start_q     <= wp_start_d;
      tmo_q          <= tmo_d;
      resp_valid_q   <= resp_valid_d;
      resp_nexthop_q <= resp_nexthop_d;
      resp_err_q     <= resp_err_d;
      eps_q          <= eps_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign q_rd_en           = q_rd_en_q;
  assign q_addr            = q_addr_q;
  assign wp_start          = wp_start_q;
  assign wp_bestvalue      = best_q;
  assign wp_bestneighborID = best_id_q;
  assign epsilon           = eps_q;
  assign resp_valid        = resp_valid_q;
  assign resp_nexthop      = resp_nexthop_q;
  assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_route_decision_sequencer.sv
// Directed bench for route_decision_sequencer: table of decisions with hand-computed
// results, epsilon decay walk to the floor, and reset in the middle of a policy wait.
module tb_route_decision_sequencer;

  logic        clock = 1'b0;
  logic        nreset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_dest;
  logic [3:0]  req_nbr_count;
  logic        q_rd_en;
  logic [9:0]  q_addr;
  logic [15:0] q_rdata = 16'd0;
  logic [15:0] nid_rdata = 16'd0;
  logic        wp_start;
  logic [15:0] wp_bestvalue;
  logic [15:0] wp_bestneighborID;
  logic        wp_done;
  logic [15:0] wp_nexthop;
  logic [15:0] epsilon;
  logic        resp_valid;
  logic [15:0] resp_nexthop;
  logic        resp_err;

  route_decision_sequencer dut (
    .clock(clock), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_nbr_count(req_nbr_count),
    .q_rd_en(q_rd_en), .q_addr(q_addr), .q_rdata(q_rdata), .nid_rdata(nid_rdata),
    .wp_start(wp_start), .wp_bestvalue(wp_bestvalue), .wp_bestneighborID(wp_bestneighborID),
    .wp_done(wp_done), .wp_nexthop(wp_nexthop),
    .epsilon(epsilon), .resp_valid(resp_valid), .resp_nexthop(resp_nexthop), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  logic [15:0] qmem  [1024];
  logic [15:0] idmem [1024];

  // Q-table memory with one-cycle read latency
  always @(posedge clock) begin
    if (q_rd_en) begin
      q_rdata   <= qmem[q_addr];
      nid_rdata <= idmem[q_addr];
    end
  end

  typedef struct packed {
    logic [6:0]  dest;
    logic [3:0]  cnt;
    int          dly;     // cycles after wp_start rises until wp_done; -1 = never
    logic [15:0] nh;
    logic        pulse;   // stray wp_done during SCAN
    int          e_rd;
    int          e_wsf;
    int          e_ws;
    int          e_resp;
    logic [15:0] e_best;
    logic [15:0] e_id;
    logic [15:0] e_nh;
    logic        e_err;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] qtab [7][8];
  logic [15:0] itab [7][8];

  int total = 0;
  int bad   = 0;

  int          r_rd, r_wsf, r_ws, r_resp;
  logic        r_seq_ok;
  logic [15:0] r_best, r_id, r_nh, r_eps;
  logic        r_err;
  logic [15:0] eps_m;
  int          cnt_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_success();
    cnt_m++;
    if (cnt_m == 16) begin
      cnt_m = 0;
      eps_m = (eps_m >= 16'd60) ? (eps_m - 16'd10) : 16'd50;
    end
  endtask

  // One decision; cycle 0 is the cycle req_valid is presented and accepted
  task automatic run(input logic [6:0] dest, input logic [3:0] cnt, input int dly,
                     input logic [15:0] nh, input logic pulse);
    int cyc;
    @(negedge clock);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_dest = dest; req_nbr_count = cnt;
    @(negedge clock);
    req_valid = 1'b0;
    r_rd = 0; r_wsf = -1; r_ws = 0; r_resp = -1; r_seq_ok = 1'b1;
    r_best = 16'hDEAD; r_id = 16'hDEAD;
    cyc = 1;
    while (r_resp < 0 && cyc < 200) begin
      if (q_rd_en) begin
        if (int'(q_addr) != int'(dest) * 8 + r_rd || cyc != r_rd + 1) r_seq_ok = 1'b0;
        r_rd++;
      end
      if (wp_start) begin
        if (r_wsf < 0) r_wsf = cyc;
        r_ws++;
        r_best = wp_bestvalue; r_id = wp_bestneighborID;
      end
      if (resp_valid) begin
        r_resp = cyc; r_nh = resp_nexthop; r_err = resp_err; r_eps = epsilon;
      end else begin
        wp_done    = (pulse && cyc == 3) || (dly >= 0 && r_wsf >= 0 && cyc == r_wsf + dly);
        wp_nexthop = nh;
        @(negedge clock);
        cyc++;
      end
    end
    wp_done = 1'b0;
    @(negedge clock);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int saw_floor;
    int seen;
    logic [15:0] prev_eps;

    nreset = 1'b0; req_valid = 1'b0; req_dest = 7'd0; req_nbr_count = 4'd0;
    wp_done = 1'b0; wp_nexthop = 16'd0;
    for (int i = 0; i < 1024; i++) begin qmem[i] = 16'd0; idmem[i] = 16'd0; end

    //           dest    cnt  dly  nh       pulse rd wsf ws  resp best       id       nh        err
    vecs[0] = '{7'd3,   4'd4,  3, 16'd11,  1'b0, 4, 6,  4,  10, 16'd9,     16'd11,  16'd11,   1'b0};
    vecs[1] = '{7'd5,   4'd0,  0, 16'd0,   1'b0, 0, -1, 0,  2,  16'd0,     16'd0,   16'hFFFF, 1'b1};
    vecs[2] = '{7'd10,  4'd8,  0, 16'd100, 1'b1, 8, 10, 1,  11, 16'd0,     16'd100, 16'd100,  1'b0};
    vecs[3] = '{7'd1,   4'd2, -1, 16'd0,   1'b0, 2, 4,  64, 68, 16'd7,     16'd40,  16'hFFFF, 1'b1};
    vecs[4] = '{7'd127, 4'd3,  1, 16'd3,   1'b0, 3, 5,  2,  7,  16'd65535, 16'd3,   16'd3,    1'b0};
    vecs[5] = '{7'd2,   4'd15, 2, 16'd25,  1'b0, 8, 10, 3,  13, 16'd9,     16'd25,  16'd25,   1'b0};
    vecs[6] = '{7'd0,   4'd1,  0, 16'd77,  1'b0, 1, 3,  1,  4,  16'd0,     16'd77,  16'd77,   1'b0};
    qtab = '{'{16'd5, 16'd9, 16'd9, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd1, 16'd2, 16'd65535, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6},
             '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    itab = '{'{16'd10, 16'd11, 16'd12, 16'd13, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107},
             '{16'd40, 16'd41, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
             '{16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27},
             '{16'd77, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};

    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_epsilon", {16'd0, epsilon}, 32'd1000);
    chk("rst_q", {21'd0, q_rd_en, q_addr}, 32'd0);
    chk("rst_wp", {wp_start, wp_bestvalue, wp_bestneighborID[14:0]}, 32'd0);
    chk("rst_resp", {14'd0, resp_valid, resp_err, resp_nexthop}, 32'd0);
    nreset = 1'b1;
    eps_m = 16'd1000; cnt_m = 0;

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 8; i++) begin
        qmem[int'(vecs[k].dest) * 8 + i]  = qtab[k][i];
        idmem[int'(vecs[k].dest) * 8 + i] = itab[k][i];
      end
      run(vecs[k].dest, vecs[k].cnt, vecs[k].dly, vecs[k].nh, vecs[k].pulse);
      if (!vecs[k].e_err) model_success();
      chk($sformatf("v%0d_resp_cycle", k), r_resp, vecs[k].e_resp);
      chk($sformatf("v%0d_reads", k), r_rd, vecs[k].e_rd);
      chk($sformatf("v%0d_read_seq", k), {31'd0, r_seq_ok}, 32'd1);
      chk($sformatf("v%0d_wp_first", k), r_wsf, vecs[k].e_wsf);
      chk($sformatf("v%0d_wp_cycles", k), r_ws, vecs[k].e_ws);
      if (vecs[k].e_ws > 0) begin
        chk($sformatf("v%0d_best", k), {16'd0, r_best}, {16'd0, vecs[k].e_best});
        chk($sformatf("v%0d_best_id", k), {16'd0, r_id}, {16'd0, vecs[k].e_id});
      end
      chk($sformatf("v%0d_nexthop", k), {16'd0, r_nh}, {16'd0, vecs[k].e_nh});
      chk($sformatf("v%0d_err", k), {31'd0, r_err}, {31'd0, vecs[k].e_err});
      chk($sformatf("v%0d_eps", k), {16'd0, r_eps}, {16'd0, eps_m});
    end

    // Successful decisions until epsilon reaches its floor, then one more interval
    saw_floor = 0;
    prev_eps = r_eps;
    for (int k = 0; k < 1531; k++) begin
      run(7'd0, 4'd1, 0, 16'd77, 1'b0);
      model_success();
      chk("decay_eps", {16'd0, r_eps}, {16'd0, eps_m});
      if (k == 10) chk("eps_first_decay", {16'd0, r_eps}, 32'd990);
      if (prev_eps == 16'd60 && r_eps == 16'd50) saw_floor++;
      prev_eps = r_eps;
    end
    chk("eps_60_to_50_once", saw_floor, 1);
    chk("eps_floor_holds", {16'd0, epsilon}, 32'd50);

    // Reset while waiting for the winner policy
    @(negedge clock);
    req_valid = 1'b1; req_dest = 7'd1; req_nbr_count = 4'd2;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !wp_start; i++) @(negedge clock);
    chk("policy_reached", {31'd0, wp_start}, 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk("midrst_wp_start", {31'd0, wp_start}, 32'd0);
    chk("midrst_epsilon", {16'd0, epsilon}, 32'd1000);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    nreset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clock);
      if (resp_valid || wp_start) seen++;
    end
    chk("midrst_no_resp", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
